// File: rtl/cache_requester.sv
// CPU-side cache initiator: one outstanding load/store, held until the cache hits or
// the wait budget runs out, with saturating hit/miss/stall statistics.
module cache_requester #(
  parameter int MAX_WAIT  = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_data,
  output logic                 req_ready,
  output logic                 resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic                 ready,
  output logic                 write_en,
  output logic [31:0]          addr,
  output logic [31:0]          data,
  input  logic                 hit,
  input  logic [31:0]          out,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] stall_cycles
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;
  logic          first;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign req_ready = (state == IDLE);
  assign wait_nxt  = wait_cnt + WW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      first        <= 1'b0;
      ready        <= 1'b0;
      write_en     <= 1'b0;
      addr         <= '0;
      data         <= '0;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      resp_data    <= '0;
      hit_count    <= '0;
      miss_count   <= '0;
      stall_cycles <= '0;
    end else if (en) begin
      // Response flags are one-enabled-cycle pulses unless re-set below.
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_en <= req_write;
            addr     <= req_addr;
            data     <= req_data;
            ready    <= 1'b1;
            wait_cnt <= '0;
            first    <= 1'b1;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (hit) begin
            resp_valid <= 1'b1;
            resp_data  <= write_en ? 32'h0 : out;
            ready      <= 1'b0;
            state      <= IDLE;
            if (first) hit_count  <= sat_inc(hit_count);
            else       miss_count <= sat_inc(miss_count);
          end else begin
            stall_cycles <= sat_inc(stall_cycles);
            first        <= 1'b0;
            wait_cnt     <= wait_nxt;
            // Budget exhausted: abandon the access and report an error response.
            if (wait_nxt == WAIT_LIM) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_data  <= 32'h0;
              ready      <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_requester.sv
// Scoreboard bench for cache_requester: default-timeout instance plus a MAX_WAIT=4 instance.
module tb_cache_requester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, en, req_valid, req_write, hit, req_valid_b, hit_b;
  logic [31:0] req_addr, req_data, out;

  logic        req_ready, resp_valid, resp_err, ready, write_en;
  logic [31:0] resp_data, addr, data, hit_count, miss_count, stall_cycles;

  logic        req_ready_b, resp_valid_b, resp_err_b, ready_b, write_en_b;
  logic [31:0] resp_data_b, addr_b, data_b, hit_count_b, miss_count_b, stall_cycles_b;

  cache_requester dut_a (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .ready(ready), .write_en(write_en), .addr(addr), .data(data),
    .hit(hit), .out(out), .hit_count(hit_count), .miss_count(miss_count),
    .stall_cycles(stall_cycles)
  );

  cache_requester #(.MAX_WAIT(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .req_valid(req_valid_b), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready_b),
    .resp_valid(resp_valid_b), .resp_data(resp_data_b), .resp_err(resp_err_b),
    .ready(ready_b), .write_en(write_en_b), .addr(addr_b), .data(data_b),
    .hit(hit_b), .out(out), .hit_count(hit_count_b), .miss_count(miss_count_b),
    .stall_cycles(stall_cycles_b)
  );

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          c;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic en_q = 1'b0;

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    en_q <= en;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // A response is new only if the edge that produced it was enabled.
  always @(negedge clk) begin : mon_a
    exp_t x;
    if (reset === 1'b1 && resp_valid === 1'b1 && en_q === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_a_unexpected: got data %h err %b at edge %0d, expected no response",
                 resp_data, resp_err, cyc);
      end else begin
        x = qa.pop_front();
        check("resp_a_data", resp_data, x.d);
        check("resp_a_err", resp_err, x.e);
        check("resp_a_edge", cyc, x.c);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t x;
    if (reset === 1'b1 && resp_valid_b === 1'b1 && en_q === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp_b_unexpected: got data %h err %b at edge %0d, expected no response",
                 resp_data_b, resp_err_b, cyc);
      end else begin
        x = qb.pop_front();
        check("resp_b_data", resp_data_b, x.d);
        check("resp_b_err", resp_err_b, x.e);
        check("resp_b_edge", cyc, x.c);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected earlier finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; en = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_data = '0; hit = 1'b0; out = '0;
    req_valid_b = 1'b0; hit_b = 1'b0;
    step(); step();
    check("rst_ready", ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_addr", addr, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_stall", stall_cycles, 0);
    reset = 1'b1;
    step();
    check("req_ready_after_reset", req_ready, 1);

    // Load, first-cycle hit.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0040;
    qa.push_back('{32'hDEAD_BEEF, 1'b0, cyc + 2});
    step();
    req_valid = 1'b0;
    check("t1_ready", ready, 1);
    check("t1_req_ready_busy", req_ready, 0);
    hit = 1'b1; out = 32'hDEAD_BEEF;
    step();
    hit = 1'b0; out = '0;
    check("t1_hit_count", hit_count, 1);
    check("t1_stall", stall_cycles, 0);

    // Store, hit on the 6th ACCESS cycle; inputs change to prove the request is held.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0100; req_data = 32'h1234_5678;
    qa.push_back('{32'h0, 1'b0, cyc + 7});
    step();
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'hFFFF_FFFF; req_data = 32'h0;
    for (int i = 0; i < 6; i++) begin
      check("t2_ready_hold", {ready, write_en}, 2'b11);
      check("t2_addr_hold", addr, 32'h0000_0100);
      check("t2_data_hold", data, 32'h1234_5678);
      hit = (i == 5);
      step();
    end
    hit = 1'b0;
    check("t2_miss_count", miss_count, 1);
    check("t2_hit_count", hit_count, 1);
    check("t2_stall", stall_cycles, 5);

    // Timeout on the MAX_WAIT=4 instance.
    req_valid_b = 1'b1; req_addr = 32'h0000_0200;
    qb.push_back('{32'h0, 1'b1, cyc + 5});
    step();
    req_valid_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t3_ready_wait", ready_b, 1);
      step();
    end
    check("t3_ready_after", ready_b, 0);
    check("t3_req_ready", req_ready_b, 1);
    check("t3_hit_miss", {hit_count_b, miss_count_b}, 64'h0);
    check("t3_stall", stall_cycles_b, 4);
    step();
    check("t3_resp_cleared", resp_valid_b, 0);

    // Back-to-back first-cycle-hit loads.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0300;
    qa.push_back('{32'hA1A1_A1A1, 1'b0, cyc + 2});
    step();
    req_valid = 1'b0; hit = 1'b1; out = 32'hA1A1_A1A1;
    step();
    hit = 1'b0; out = '0;
    check("t4_req_ready_with_resp", {req_ready, resp_valid}, 2'b11);
    req_valid = 1'b1; req_addr = 32'h0000_0304;
    qa.push_back('{32'hB2B2_B2B2, 1'b0, cyc + 2});
    step();
    req_valid = 1'b0; hit = 1'b1; out = 32'hB2B2_B2B2;
    step();
    hit = 1'b0; out = '0;
    check("t4_hit_count", hit_count, 3);

    // Freeze mid-ACCESS with hit asserted, then freeze with a response pending.
    req_valid = 1'b1; req_addr = 32'h0000_0400;
    qa.push_back('{32'hC3C3_C3C3, 1'b0, cyc + 5});
    step();
    req_valid = 1'b0; en = 1'b0; hit = 1'b1; out = 32'hC3C3_C3C3;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_frozen_ready", {ready, resp_valid}, 2'b10);
      check("t5_frozen_hits", hit_count, 3);
      check("t5_frozen_stall", stall_cycles, 5);
    end
    en = 1'b1;
    step();
    hit = 1'b0; out = '0; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t5_resp_held", resp_valid, 1);
      check("t5_resp_data_held", resp_data, 32'hC3C3_C3C3);
    end
    en = 1'b1;
    step();
    check("t5_resp_cleared", resp_valid, 0);
    check("t5_hit_count", hit_count, 4);
    check("t5_stall", stall_cycles, 5);

    // Asynchronous reset between edges while a miss is outstanding.
    req_valid = 1'b1; req_addr = 32'h0000_0500;
    step();
    req_valid = 1'b0;
    step();
    #2;
    reset = 1'b0;
    #1;
    check("t6_ready_async", ready, 0);
    check("t6_counts_async", {hit_count, miss_count}, 64'h0);
    check("t6_stall_async", stall_cycles, 0);
    check("t6_resp_async", resp_valid, 0);
    reset = 1'b1;
    step();
    check("t6_req_ready", req_ready, 1);
    hit = 1'b1; out = 32'h5555_5555;
    step();
    hit = 1'b0;
    step(); step();
    check("t6_no_resp", resp_valid, 0);
    check("t6_stall_after", stall_cycles, 0);

    check("queue_a_drained", qa.size(), 0);
    check("queue_b_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cache_requester.md
# cache_requester

Initiator for the cache's CPU-side port. It accepts one load/store at a time from the pipeline and drives `ready`/`write_en`/`addr`/`data` to the cache. It holds the request stable until the cache reports `hit`, then returns the result with a one-cycle response. It also bounds miss latency with a timeout and keeps hit/miss/stall statistics for performance runs.

## Interface
Parameters:
- `MAX_WAIT`, default 64: cache-not-hit cycles tolerated per request before timeout (≥1).
- `CNT_WIDTH`, default 32: width of the statistics counters.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low; 0 clears all state immediately.
- `en` in 1: 0 freezes all state, counters and outputs.
- `req_valid` in 1: pipeline request present.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_data` in 32: store data.
- `req_ready` out 1: block can accept a request this cycle (state IDLE).
- `resp_valid` out 1: response pulse.
- `resp_data` out 32: load data; 0 for stores and timeouts.
- `resp_err` out 1: qualifies `resp_valid`; 1 = timeout.
- `ready` out 1: cache access issue.
- `write_en` out 1: cache write select.
- `addr` out 32: cache address.
- `data` out 32: cache write data.
- `hit` in 1: cache completed the access this cycle.
- `out` in 32: cache read data.
- `hit_count` out CNT_WIDTH: requests completed with `hit` in their first ACCESS cycle.
- `miss_count` out CNT_WIDTH: requests completed with `hit` in a later ACCESS cycle.
- `stall_cycles` out CNT_WIDTH: total ACCESS cycles with `hit`=0.

## Operation
- FSM has two states: IDLE and ACCESS. All outputs are registered except `req_ready`, which equals (state==IDLE).
- IDLE:
  - On `en` & `req_valid`: latch `req_write`/`req_addr`/`req_data` into `write_en`/`addr`/`data`.
  - Set `ready`=1, clear the wait counter, record first=1, go to ACCESS.
  - `req_valid` with `en`=0 is not accepted.
- ACCESS (`ready`=1, `addr`/`data`/`write_en` held constant):
  - `hit`=1:
    - `resp_valid`←1, `resp_err`←0.
    - `resp_data`←`out` for loads, 0 for stores.
    - `ready`←0, state←IDLE.
    - `hit_count`+1 if first, else `miss_count`+1.
  - `hit`=0:
    - `stall_cycles`+1, first←0, wait counter+1.
    - If the wait counter reaches `MAX_WAIT`: `resp_valid`←1, `resp_err`←1, `resp_data`←0, `ready`←0, state←IDLE. A timeout counts in neither hit nor miss.
- `resp_valid`/`resp_err` clear on the next enabled edge unless re-set. A response therefore lasts exactly one enabled cycle and stretches across `en`=0 cycles.
- All counters saturate at all-ones; no wrap.
- `req_*` inputs are ignored outside IDLE. The block never queues a second request.

## Timing
- Reset (asynchronous, `reset`=0):
  - State IDLE.
  - `ready`, `write_en`, `resp_valid`, `resp_err` = 0.
  - `addr`, `data`, `resp_data` = 0.
  - All counters = 0.
  - `req_ready` = 1 once `reset` is released.
- Reset asserted mid-ACCESS drops `ready` immediately; no response is produced for the lost request.
- Latency, with request accepted at edge N:
  - `ready` is high in cycle N+1.
  - Hit in cycle N+k gives `resp_valid` in cycle N+k+1. Minimum is 2 cycles, with hit in the first ACCESS cycle.
- Back-to-back: `req_ready`=1 in the same cycle `resp_valid`=1, so the next request can be accepted then. Sustained throughput is 1 request per 2 cycles.
- Timeout: after `MAX_WAIT` consecutive `hit`=0 ACCESS cycles, `resp_err` pulses on the following cycle. `hit` arriving in the same cycle as the `MAX_WAIT`-th wait does not occur by definition: hit takes priority in that cycle.
- `en`=0 in ACCESS: `ready` stays high, nothing is counted, and `hit` is ignored that cycle.

## Test plan
- Reset, then load to 0x0000_0040. Cache returns `hit`=1, `out`=0xDEAD_BEEF in the first ACCESS cycle. Required:
  - `resp_valid` 2 cycles after acceptance.
  - `resp_data`=0xDEAD_BEEF.
  - `hit_count`=1, `stall_cycles`=0.
- Store 0x1234_5678 to 0x0000_0100 with `hit` delayed 5 cycles. Required:
  - `ready`/`write_en`/`addr`/`data` stable for 6 ACCESS cycles.
  - `resp_data`=0.
  - `miss_count`=1, `stall_cycles`=5.
- `MAX_WAIT`=4, `hit` never asserted. Required:
  - `resp_valid`=1 and `resp_err`=1 on the 5th cycle after acceptance.
  - `ready` low afterwards.
  - Hit and miss counters unchanged; `stall_cycles`=4.
- Two back-to-back loads, both first-cycle hits. Required:
  - Second request accepted in the cycle of the first `resp_valid`.
  - Responses 2 cycles apart.
  - `hit_count`=2.
- `en`=0 for 3 cycles mid-ACCESS while `hit`=1, then `en`=1. Required:
  - Frozen state, no counter change.
  - Response issued after re-enable.
  - A `resp_valid` already asserted holds through the frozen cycles.
- Assert `reset` low mid-ACCESS between clock edges. Required:
  - `ready`=0 and all counters 0 immediately.
  - `req_ready`=1 after release.
  - No `resp_valid`.
